perf_event_monitor: RTL and testbench

- Synthesizable on-chip counterpart of the simulation-only metric collection for the pipelined RISC-V core.
- Consumes per-cycle Execute-stage event strobes from the pipeline and maintains saturating counters: cycles, instructions, branches, correctly predicted branches, jumps and stores.
- Detects end-of-program idle and freezes all counters.
- Exposes the counters through a one-cycle-latency register read port for a debug or MMIO bridge.

---
 rtl/perf_pkg.sv | 21 ++
 rtl/perf_sat_counter.sv | 32 +++
 rtl/perf_event_monitor.sv | 115 +++++++++++
 tb/tb_perf_event_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the performance event monitor: register map, status
// layout and the default monitor identifier.
package perf_pkg;

  typedef enum logic [2:0] {
    ADDR_LATENCY = 3'd0,
    ADDR_INSTR   = 3'd1,
    ADDR_BR      = 3'd2,
    ADDR_BR_OK   = 3'd3,
    ADDR_JMP     = 3'd4,
    ADDR_ST      = 3'd5,
    ADDR_STATUS  = 3'd6,
    ADDR_ID      = 3'd7
  } perf_addr_e;

  localparam int          STAT_DONE_BIT  = 4;
  localparam int          STAT_IDLE_LSB  = 0;
  localparam int          STAT_W         = STAT_DONE_BIT + 1;
  localparam logic [31:0] MON_ID_DEFAULT = 32'h5046_0001;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: the default is assigned first so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Execute-stage event counters with end-of-program idle detection and a
// one-cycle-latency register read port.
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          IDLE_LIMIT = 5,
  parameter logic [31:0] MON_ID     = MON_ID_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reg_write_e,
  input  logic             mem_write_e,
  input  logic             branch_e,
  input  logic             jump_e,
  input  logic             pc_src_e,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             done
);

  // Wide enough to hold IDLE_LIMIT and always at least the 4 bits shown in status.
  localparam int IDLE_W = ($clog2(IDLE_LIMIT + 1) > 4) ? $clog2(IDLE_LIMIT + 1) : 4;

  logic              active, count_en;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt, br_cnt, br_ok_cnt, jmp_cnt, st_cnt;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  latency, rd_mux;
  logic [STAT_W-1:0] status;

  assign active   = reg_write_e | mem_write_e | branch_e | jump_e;
  assign count_en = !clear && !done_q;

  perf_sat_counter #(.W(CNT_W)) u_cycle (.clock, .reset, .clr(clear), .inc(count_en),                         .q(cycle_cnt));
  perf_sat_counter #(.W(CNT_W)) u_instr (.clock, .reset, .clr(clear), .inc(count_en && active),               .q(instr_cnt));
  perf_sat_counter #(.W(CNT_W)) u_br    (.clock, .reset, .clr(clear), .inc(count_en && branch_e),             .q(br_cnt));
  perf_sat_counter #(.W(CNT_W)) u_br_ok (.clock, .reset, .clr(clear), .inc(count_en && branch_e && !pc_src_e), .q(br_ok_cnt));
  perf_sat_counter #(.W(CNT_W)) u_jmp   (.clock, .reset, .clr(clear), .inc(count_en && jump_e),               .q(jmp_cnt));
  perf_sat_counter #(.W(CNT_W)) u_st    (.clock, .reset, .clr(clear), .inc(count_en && mem_write_e),          .q(st_cnt));

  // done is raised on the idle edge that completes the run, so that edge is still counted.
  always_comb begin
    idle_d = idle_q;
    done_d = done_q;
    if (clear) begin
      idle_d = '0;
      done_d = 1'b0;
    end else if (count_en) begin
      if (active) begin
        idle_d = '0;
      end else begin
        if (idle_q != IDLE_W'(IDLE_LIMIT)) idle_d = idle_q + IDLE_W'(1);
        if (idle_q == IDLE_W'(IDLE_LIMIT - 1)) done_d = 1'b1;
      end
    end
  end

  always_comb begin
    latency = cycle_cnt;
    if (done_q) begin
      latency = (cycle_cnt >= CNT_W'(IDLE_LIMIT)) ? cycle_cnt - CNT_W'(IDLE_LIMIT) : '0;
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_DONE_BIT] = done_q;
    status[STAT_IDLE_LSB +: 4] = idle_q[3:0];
  end

  always_comb begin
    rd_mux = '0;
    case (perf_addr_e'(rd_addr))
      ADDR_LATENCY: rd_mux = latency;
      ADDR_INSTR:   rd_mux = instr_cnt;
      ADDR_BR:      rd_mux = br_cnt;
      ADDR_BR_OK:   rd_mux = br_ok_cnt;
      ADDR_JMP:     rd_mux = jmp_cnt;
      ADDR_ST:      rd_mux = st_cnt;
      ADDR_STATUS:  rd_mux = CNT_W'(status);
      ADDR_ID:      rd_mux = CNT_W'(MON_ID);
      default:      rd_mux = '0;
    endcase
  end

  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q     <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      idle_q     <= idle_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Scoreboard bench: stimulus queues expected read data and done/valid probes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_perf_event_monitor;
  import perf_pkg::*;

  localparam int MAX_CYC = 5000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT A: default parameters
  logic        reset, clear, reg_write_e, mem_write_e, branch_e, jump_e, pc_src_e;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        rd_valid, done;
  logic [31:0] rd_data;

  // DUT B: narrow counters for saturation
  logic        reset_b, clear_b, rw_b, mw_b, br_b, jp_b, ps_b, rd_req_b;
  logic [2:0]  rd_addr_b;
  logic        rd_valid_b, done_b;
  logic [3:0]  rd_data_b;

  perf_event_monitor u_dut (
    .clock(clock), .reset(reset), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .jump_e(jump_e), .pc_src_e(pc_src_e), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .done(done)
  );

  perf_event_monitor #(.CNT_W(4)) u_dut_b (
    .clock(clock), .reset(reset_b), .reg_write_e(rw_b), .mem_write_e(mw_b),
    .branch_e(br_b), .jump_e(jp_b), .pc_src_e(ps_b), .clear(clear_b),
    .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .done(done_b)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  typedef struct {
    string name;
    bit    is_valid;
    logic  exp;
  } probe_t;

  rd_exp_t qa[$];
  rd_exp_t qb[$];
  probe_t  pq[$];
  bit      stim_done = 1'b0;
  int      checks    = 0;
  int      failures  = 0;
  int      cyc       = 0;
  rd_exp_t ea, eb;
  probe_t  pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ev(input logic rw, input logic mw, input logic br, input logic jp, input logic ps);
    reg_write_e = rw; mem_write_e = mw; branch_e = br; jump_e = jp; pc_src_e = ps;
    tick();
    reg_write_e = 0; mem_write_e = 0; branch_e = 0; jump_e = 0; pc_src_e = 0;
  endtask

  task automatic rd_a(input logic [2:0] a, input logic [31:0] e, input string n);
    rd_req = 1'b1; rd_addr = a;
    qa.push_back('{n, e});
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_b(input logic [2:0] a, input logic [31:0] e, input string n);
    rd_req_b = 1'b1; rd_addr_b = a;
    qb.push_back('{n, e});
    tick();
    rd_req_b = 1'b0;
  endtask

  task automatic probe_done(input logic e, input string n);
    pq.push_back('{n, 1'b0, e});
  endtask

  task automatic probe_valid(input logic e, input string n);
    pq.push_back('{n, 1'b1, e});
  endtask

  // Monitor: the only process that compares or touches the counts.
  always @(negedge clock) begin
    cyc++;
    if (rd_valid) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid_a: got rd_valid=1 data=0x%0h required no response", rd_data);
      end else begin
        ea = qa.pop_front();
        check(ea.name, rd_data, ea.exp);
      end
    end
    if (rd_valid_b) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid_b: got rd_valid=1 data=0x%0h required no response", rd_data_b);
      end else begin
        eb = qb.pop_front();
        check(eb.name, 32'(rd_data_b), eb.exp);
      end
    end
    if (pq.size() != 0) begin
      pe = pq.pop_front();
      check(pe.name, pe.is_valid ? 32'(rd_valid) : 32'(done), 32'(pe.exp));
    end
    if ((stim_done && qa.size() == 0 && qb.size() == 0 && pq.size() == 0) || cyc >= MAX_CYC) begin
      if (!stim_done || qa.size() != 0 || qb.size() != 0 || pq.size() != 0) begin
        checks++; failures++;
        $display("FAIL timeout: got pending reads=%0d/%0d probes=%0d stim_done=%0d required all 0 and stim_done=1",
                 qa.size(), qb.size(), pq.size(), stim_done);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    reset = 1; clear = 0; reg_write_e = 0; mem_write_e = 0; branch_e = 0; jump_e = 0; pc_src_e = 0;
    rd_req = 0; rd_addr = '0;
    reset_b = 1; clear_b = 0; rw_b = 0; mw_b = 0; br_b = 0; jp_b = 0; ps_b = 0;
    rd_req_b = 0; rd_addr_b = '0;
    repeat (3) tick();
    probe_valid(1'b0, "rst_valid");
    probe_done(1'b0, "rst_done");
    reset = 0;

    // Reset state: each read edge is itself an idle counted cycle.
    rd_a(ADDR_INSTR,   32'd0, "rst_instr");
    rd_a(ADDR_LATENCY, 32'd1, "rst_cycle");
    rd_a(ADDR_STATUS,  32'd2, "rst_status");

    // 10 active cycles, then done on the 5th idle edge.
    clear = 1; tick(); clear = 0;
    repeat (10) ev(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      ev(0, 0, 0, 0, 0);
      probe_done(i == 5, $sformatf("s1_done_idle%0d", i));
    end
    rd_a(ADDR_LATENCY, 32'd10,         "s1_latency");
    rd_a(ADDR_INSTR,   32'd10,         "s1_instr");
    rd_a(ADDR_STATUS,  32'h15,         "s1_status");
    rd_a(ADDR_BR,      32'd0,          "s1_br");
    rd_a(ADDR_ID,      32'h5046_0001,  "s1_id");

    // Branch / store / jump mix.
    clear = 1; tick(); clear = 0;
    ev(0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0);
    ev(0, 0, 1, 0, 1);
    ev(0, 1, 0, 0, 0);
    ev(0, 0, 0, 1, 0);
    ev(0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0);
    ev(0, 0, 1, 0, 0);
    repeat (4) ev(0, 0, 0, 0, 0);
    ev(0, 0, 0, 0, 0);
    probe_done(1'b1, "s2_done");
    rd_a(ADDR_BR,      32'd4, "s2_br");
    rd_a(ADDR_BR_OK,   32'd3, "s2_br_ok");
    rd_a(ADDR_ST,      32'd3, "s2_st");
    rd_a(ADDR_JMP,     32'd1, "s2_jmp");
    rd_a(ADDR_INSTR,   32'd8, "s2_instr");
    rd_a(ADDR_LATENCY, 32'd8, "s2_latency");

    // 4 idle, 1 active, 4 idle keeps done low; a 5th idle sets it.
    clear = 1; tick(); clear = 0;
    for (int i = 1; i <= 4; i++) begin
      ev(0, 0, 0, 0, 0);
      probe_done(1'b0, $sformatf("s3_done_a%0d", i));
    end
    ev(1, 0, 0, 0, 0);
    probe_done(1'b0, "s3_done_active");
    for (int i = 1; i <= 4; i++) begin
      ev(0, 0, 0, 0, 0);
      probe_done(1'b0, $sformatf("s3_done_b%0d", i));
    end
    ev(0, 0, 0, 0, 0);
    probe_done(1'b1, "s3_done_fifth");
    rd_a(ADDR_LATENCY, 32'd5,  "s3_latency");
    rd_a(ADDR_INSTR,   32'd1,  "s3_instr");
    rd_a(ADDR_STATUS,  32'h15, "s3_status");

    // Frozen after done.
    repeat (20) ev(1, 1, 1, 1, 1);
    probe_done(1'b1, "s4_done_held");
    rd_a(ADDR_INSTR,   32'd1,  "s4_frozen_instr");
    rd_a(ADDR_LATENCY, 32'd5,  "s4_frozen_latency");
    rd_a(ADDR_BR,      32'd0,  "s4_frozen_br");
    rd_a(ADDR_ST,      32'd0,  "s4_frozen_st");
    rd_a(ADDR_JMP,     32'd0,  "s4_frozen_jmp");
    rd_a(ADDR_STATUS,  32'h15, "s4_frozen_status");

    // Clear with a same-edge branch and read: read returns pre-clear value.
    clear = 1; branch_e = 1;
    rd_a(ADDR_INSTR, 32'd1, "s4_clr_preval");
    branch_e = 0;
    probe_done(1'b0, "s4_clr_done");
    for (int a = 0; a < 7; a++) rd_a(3'(a), 32'd0, $sformatf("s4_clr_addr%0d", a));
    rd_a(ADDR_ID, 32'h5046_0001, "s4_clr_id");
    clear = 0;
    ev(1, 0, 0, 0, 0);
    rd_a(ADDR_INSTR,   32'd1, "s4_resume_instr");
    rd_a(ADDR_LATENCY, 32'd2, "s4_resume_cycle");

    clear = 1; branch_e = 1;
    rd_a(ADDR_INSTR, 32'd1, "s5_clr_instr_pre");
    clear = 0; branch_e = 0;
    rd_a(ADDR_BR,    32'd0, "s5_br_lost");
    rd_a(ADDR_INSTR, 32'd0, "s5_instr_cleared");

    // Reset during a read.
    ev(1, 1, 1, 1, 0);
    ev(1, 1, 1, 1, 0);
    rd_req = 1; rd_addr = ADDR_INSTR; reset = 1;
    tick();
    rd_req = 0;
    probe_valid(1'b0, "s6_rst_valid");
    reset = 0;
    rd_a(ADDR_INSTR, 32'd0, "s6_instr");
    rd_a(ADDR_ST,    32'd0, "s6_st");
    rd_a(ADDR_BR,    32'd0, "s6_br");

    // Narrow counters saturate at 15.
    reset_b = 0;
    rw_b = 1; br_b = 1;
    repeat (20) tick();
    rw_b = 0; br_b = 0;
    rd_b(ADDR_INSTR,   32'd15, "b_instr_sat");
    rd_b(ADDR_ID,      32'h1,  "b_id_trunc");
    rd_b(ADDR_BR,      32'd15, "b_br_sat");
    rd_b(ADDR_LATENCY, 32'd15, "b_cycle_sat");

    stim_done = 1'b1;
  end

endmodule
